// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: scheduler states,
// branch kinds and the fetch-group index/tag slices.
package bpu_pkg;

   localparam int BPU_ADDR_W = 32;
   localparam int BPU_HASH_D = 5;
   localparam int BPU_HASH_W = 24;

   localparam logic [1:0] KIND_RET  = 2'b11;
   localparam logic [1:0] KIND_COND = 2'b01;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bpu_state_e;

   // One entry per 8-byte fetch group; tag sits directly above the index.
   function automatic logic [BPU_HASH_D-1:0] bpu_idx(
      input logic [BPU_ADDR_W-1:0] pc
   );
      return pc[BPU_HASH_D+2:3];
   endfunction

   function automatic logic [BPU_HASH_W-1:0] bpu_tag(
      input logic [BPU_ADDR_W-1:0] pc
   );
      return pc[BPU_HASH_W+BPU_HASH_D+2:BPU_HASH_D+3];
   endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// Small synchronous FIFO holding resolved branch updates
// until the table port is free.
module bpu_update_fifo
   import bpu_pkg::*;
#(
   parameter int DW    = 67,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DW-1:0]              din_i,
   output logic [DW-1:0]              dout_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [PW:0]   cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i)  rd_q <= rd_q + PW'(1);
         unique case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; the count qualifies every read.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/bpu_table_scheduler.sv
// Single-port predictor table scheduler: init sweep, then
// arbitration between fetch lookups and queued EX updates.
module bpu_table_scheduler
   import bpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int HASH_DEPTH = 5,
   parameter int HASH_WIDTH = 24,
   parameter int UQ_DEPTH   = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lk_req,
   input  logic [ADDR_WIDTH-1:0] lk_pc,
   output logic                  lk_gnt,
   output logic                  lk_rvld,
   output logic                  fetch_stall,
   input  logic                  up_vld,
   output logic                  up_rdy,
   input  logic [ADDR_WIDTH-1:0] up_pc,
   input  logic [ADDR_WIDTH-1:0] up_target,
   input  logic [1:0]            up_kind,
   input  logic                  up_taken,
   output logic                  tbl_en,
   output logic                  tbl_we,
   output logic [HASH_DEPTH-1:0] tbl_idx,
   output logic                  tbl_wvalid,
   output logic [HASH_WIDTH-1:0] tbl_wtag,
   output logic [ADDR_WIDTH-1:0] tbl_wtarget,
   output logic [1:0]            tbl_wkind,
   output logic                  tbl_wtaken,
   output logic                  init_done
);

   localparam int DW  = 2*ADDR_WIDTH + 3;
   localparam int CW  = $clog2(UQ_DEPTH) + 1;
   localparam int AGW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(UQ_DEPTH);
   localparam logic [AGW-1:0] MAX_AGE  = AGW'(MAX_WAIT);

   bpu_state_e            state_q, state_d;
   logic [HASH_DEPTH-1:0] sweep_q, sweep_d;
   logic [AGW-1:0]        age_q, age_d;
   logic                  rvld_q;
   logic                  done_q, done_d;

   logic [DW-1:0]         hd;
   logic [ADDR_WIDTH-1:0] hd_pc;
   logic [CW-1:0]         cnt;
   logic                  push;
   logic                  pop;
   logic                  force_wr;
   logic                  unused_pc;

   bpu_update_fifo #(
      .DW    (DW),
      .DEPTH (UQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clr_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({up_pc, up_target, up_kind, up_taken}),
      .dout_o  (hd),
      .count_o (cnt)
   );

   assign hd_pc     = hd[DW-1 -: ADDR_WIDTH];
   assign unused_pc = ^{lk_pc, hd_pc};

   assign up_rdy   = (state_q == ST_RUN) && (cnt < FULL_CNT);
   assign push     = up_vld && up_rdy;
   assign force_wr = (cnt == FULL_CNT) || (age_q >= MAX_AGE);

   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      age_d       = age_q;
      done_d      = done_q;
      pop         = 1'b0;
      lk_gnt      = 1'b0;
      tbl_en      = 1'b0;
      tbl_we      = 1'b0;
      tbl_idx     = '0;
      tbl_wvalid  = 1'b0;
      tbl_wtag    = '0;
      tbl_wtarget = '0;
      tbl_wkind   = '0;
      tbl_wtaken  = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            tbl_en  = 1'b1;
            tbl_we  = 1'b1;
            tbl_idx = sweep_q;
            sweep_d = sweep_q + HASH_DEPTH'(1);
            if (sweep_q == '1) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end
         end
         ST_RUN: begin
            // Queued updates yield to fetch unless full or stale.
            if ((cnt != '0) && (force_wr || !lk_req)) begin
               pop         = 1'b1;
               tbl_en      = 1'b1;
               tbl_we      = 1'b1;
               tbl_idx     = hd_pc[HASH_DEPTH+2:3];
               tbl_wvalid  = 1'b1;
               tbl_wtag    = hd_pc[HASH_WIDTH+HASH_DEPTH+2:HASH_DEPTH+3];
               tbl_wtarget = hd[ADDR_WIDTH+2:3];
               tbl_wkind   = hd[2:1];
               tbl_wtaken  = hd[0];
            end else if (lk_req) begin
               lk_gnt  = 1'b1;
               tbl_en  = 1'b1;
               tbl_idx = lk_pc[HASH_DEPTH+2:3];
            end
            if (pop || (cnt == '0)) begin
               age_d = '0;
            end else if (age_q < MAX_AGE) begin
               age_d = age_q + AGW'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign fetch_stall = lk_req && !lk_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
         age_q   <= '0;
         rvld_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         age_q   <= age_d;
         rvld_q  <= lk_gnt;
         done_q  <= done_d;
      end
   end

   assign lk_rvld   = rvld_q;
   assign init_done = done_q;

endmodule

// File: tb/tb_bpu_table_scheduler.sv
// Randomised bench for bpu_table_scheduler against a
// queue-based reference model of the port arbitration.
module tb_bpu_table_scheduler;

   localparam int AW = 32;
   localparam int HD = 5;
   localparam int HW = 24;
   localparam int UQ = 4;
   localparam int MW = 8;
   localparam int NENT = 1 << HD;

   typedef struct {
      logic [AW-1:0] pc;
      logic [AW-1:0] tgt;
      logic [1:0]    kind;
      logic          tk;
   } upd_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          lk_req;
   logic [AW-1:0] lk_pc;
   logic          lk_gnt, lk_rvld, fetch_stall;
   logic          up_vld, up_rdy;
   logic [AW-1:0] up_pc, up_target;
   logic [1:0]    up_kind;
   logic          up_taken;
   logic          tbl_en, tbl_we, tbl_wvalid, tbl_wtaken;
   logic [HD-1:0] tbl_idx;
   logic [HW-1:0] tbl_wtag;
   logic [AW-1:0] tbl_wtarget;
   logic [1:0]    tbl_wkind;
   logic          init_done;

   always #5 clk = ~clk;

   bpu_table_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .lk_req      (lk_req),
      .lk_pc       (lk_pc),
      .lk_gnt      (lk_gnt),
      .lk_rvld     (lk_rvld),
      .fetch_stall (fetch_stall),
      .up_vld      (up_vld),
      .up_rdy      (up_rdy),
      .up_pc       (up_pc),
      .up_target   (up_target),
      .up_kind     (up_kind),
      .up_taken    (up_taken),
      .tbl_en      (tbl_en),
      .tbl_we      (tbl_we),
      .tbl_idx     (tbl_idx),
      .tbl_wvalid  (tbl_wvalid),
      .tbl_wtag    (tbl_wtag),
      .tbl_wtarget (tbl_wtarget),
      .tbl_wkind   (tbl_wkind),
      .tbl_wtaken  (tbl_wtaken),
      .init_done   (init_done)
   );

   upd_t q[$];
   bit   m_init;
   int   m_sweep;
   int   m_age;
   bit   m_rvld;
   bit   m_done;
   int   total = 0;
   int   bad = 0;
   int   sweep_wr = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic upd_t rnd_upd();
      upd_t u;
      u.pc   = $urandom;
      u.tgt  = $urandom;
      u.kind = 2'($urandom_range(0, 3));
      u.tk   = 1'($urandom_range(0, 1));
      return u;
   endfunction

   task automatic model_reset();
      q.delete();
      m_init  = 1'b1;
      m_sweep = 0;
      m_age   = 0;
      m_rvld  = 1'b0;
      m_done  = 1'b0;
   endtask

   task automatic cyc(input bit r, input bit lr, input logic [AW-1:0] lpc,
                      input bit uv, input upd_t u);
      bit            e_en, e_we, e_gnt, e_rdy, e_pop, e_wv, e_tk, frc;
      logic [HD-1:0] e_idx;
      logic [HW-1:0] e_tag;
      logic [AW-1:0] e_tgt;
      logic [1:0]    e_kind;
      int            n;
      @(negedge clk);
      rst = r; lk_req = lr; lk_pc = lpc; up_vld = uv;
      up_pc = u.pc; up_target = u.tgt; up_kind = u.kind; up_taken = u.tk;
      #1;
      n = q.size();
      {e_en, e_we, e_gnt, e_rdy, e_pop, e_wv, e_tk} = '0;
      e_idx = '0; e_tag = '0; e_tgt = '0; e_kind = '0;
      if (m_init) begin
         e_en = 1; e_we = 1; e_idx = HD'(m_sweep);
      end else begin
         e_rdy = (n < UQ);
         frc   = (n == UQ) || (m_age >= MW);
         if (n > 0 && (frc || !lr)) begin
            e_pop = 1; e_en = 1; e_we = 1; e_wv = 1;
            e_idx  = q[0].pc[HD+2:3];
            e_tag  = q[0].pc[HW+HD+2:HD+3];
            e_tgt  = q[0].tgt;
            e_kind = q[0].kind;
            e_tk   = q[0].tk;
         end else if (lr) begin
            e_en = 1; e_gnt = 1; e_idx = lpc[HD+2:3];
         end
      end
      chk("tbl_en", 64'(tbl_en), 64'(e_en));
      chk("tbl_we", 64'(tbl_we), 64'(e_we));
      chk("lk_gnt", 64'(lk_gnt), 64'(e_gnt));
      chk("fetch_stall", 64'(fetch_stall), 64'(lr && !e_gnt));
      chk("up_rdy", 64'(up_rdy), 64'(e_rdy));
      chk("lk_rvld", 64'(lk_rvld), 64'(m_rvld));
      chk("init_done", 64'(init_done), 64'(m_done));
      if (e_en) chk("tbl_idx", 64'(tbl_idx), 64'(e_idx));
      if (e_we) begin
         chk("tbl_wvalid", 64'(tbl_wvalid), 64'(e_wv));
         chk("tbl_wtag", 64'(tbl_wtag), 64'(e_tag));
         chk("tbl_wtarget", 64'(tbl_wtarget), 64'(e_tgt));
         chk("tbl_wkind", 64'(tbl_wkind), 64'(e_kind));
         chk("tbl_wtaken", 64'(tbl_wtaken), 64'(e_tk));
      end
      if (tbl_we === 1'b1 && tbl_wvalid === 1'b0) sweep_wr++;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         m_rvld = e_gnt;
         if (m_init) begin
            m_sweep++;
            if (m_sweep == NENT) begin
               m_init = 0;
               m_done = 1;
            end
         end else begin
            if (e_pop || n == 0) m_age = 0;
            else if (m_age < MW) m_age++;
            if (e_pop) void'(q.pop_front());
            if (uv && e_rdy) q.push_back(u);
         end
      end
   endtask

   initial begin
      upd_t u;
      rst = 1'b1; lk_req = 1'b1; lk_pc = '0; up_vld = 1'b0;
      up_pc = '0; up_target = '0; up_kind = '0; up_taken = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      cyc(1, 1, $urandom, 0, rnd_upd());

      // sweep with fetch requesting throughout
      sweep_wr = 0;
      for (int i = 0; i < NENT + 2; i++)
         cyc(0, 1, $urandom, 1'($urandom_range(0, 1)), rnd_upd());
      chk("sweep_len", 64'(sweep_wr), 64'(NENT));

      // single update while fetch is idle
      u.pc = 32'h1C000048; u.tgt = 32'h1C000100; u.kind = 2'b01; u.tk = 1;
      cyc(0, 0, '0, 1, u);
      cyc(0, 0, '0, 0, rnd_upd());
      cyc(0, 0, '0, 0, rnd_upd());

      // fill the FIFO under continuous fetch, then drain
      for (int i = 0; i < 6; i++) cyc(0, 1, $urandom, 1, rnd_upd());
      for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0, rnd_upd());
      for (int i = 0; i < 6; i++) cyc(0, 0, '0, 0, rnd_upd());

      // lone update ages out under continuous fetch
      cyc(0, 1, $urandom, 1, rnd_upd());
      for (int i = 0; i < 12; i++) cyc(0, 1, $urandom, 0, rnd_upd());

      // push refused at full while a pop drains, then wrap
      for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 1, rnd_upd());
      cyc(0, 0, '0, 1, rnd_upd());
      cyc(0, 0, '0, 1, rnd_upd());
      for (int i = 0; i < 8; i++) cyc(0, 0, '0, 0, rnd_upd());

      // reset with updates pending
      for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 1, rnd_upd());
      cyc(1, 1, $urandom, 0, rnd_upd());
      sweep_wr = 0;
      for (int i = 0; i < NENT + 2; i++)
         cyc(0, 1'($urandom_range(0, 1)), $urandom, 1, rnd_upd());
      chk("resweep_len", 64'(sweep_wr), 64'(NENT));

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 9) < 7), $urandom,
             ($urandom_range(0, 9) < 4), rnd_upd());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
